// File: rtl/ex_mc_sched_pkg.sv
// Shared types, ALU function codes and default latencies for the execute-stage
// multi-cycle scheduler.
package ex_sched_pkg;

  localparam int unsigned DIV_LAT_DEF = 33;
  localparam int unsigned FPU_LAT_DEF = 4;

  localparam logic [4:0] ALU_ADD     = 5'h00;
  localparam logic [4:0] ALU_SUB     = 5'h01;
  localparam logic [4:0] ALU_SLT     = 5'h02;
  localparam logic [4:0] ALU_SLTU    = 5'h03;
  localparam logic [4:0] ALU_AND     = 5'h04;
  localparam logic [4:0] ALU_OR      = 5'h05;
  localparam logic [4:0] ALU_XOR     = 5'h06;
  localparam logic [4:0] ALU_SLL     = 5'h07;
  localparam logic [4:0] ALU_SRL     = 5'h08;
  localparam logic [4:0] ALU_SRA     = 5'h09;
  localparam logic [4:0] ALU_MUL     = 5'h0A;
  localparam logic [4:0] ALU_MULH    = 5'h0B;
  localparam logic [4:0] ALU_MULHSU  = 5'h0C;
  localparam logic [4:0] ALU_MULHU   = 5'h0D;
  localparam logic [4:0] ALU_DIV     = 5'h0E;
  localparam logic [4:0] ALU_DIVU    = 5'h0F;
  localparam logic [4:0] ALU_REM     = 5'h10;
  localparam logic [4:0] ALU_REMU    = 5'h11;
  localparam logic [4:0] ALU_FCVTSW  = 5'h12;
  localparam logic [4:0] ALU_FCVTSWU = 5'h13;
  localparam logic [4:0] ALU_FCVTWS  = 5'h14;
  localparam logic [4:0] ALU_FCVTWUS = 5'h15;
  localparam logic [4:0] ALU_FMULS   = 5'h16;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sched_state_e;
  typedef enum logic [1:0] {CL_NONE, CL_DIV, CL_FPU} op_class_e;

  function automatic op_class_e op_class(input logic [4:0] func);
    op_class_e cls;
    case (func)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:                        cls = CL_DIV;
      ALU_FCVTSW, ALU_FCVTSWU, ALU_FCVTWS, ALU_FCVTWUS, ALU_FMULS: cls = CL_FPU;
      default:                                                     cls = CL_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ex_mc_sched_if.sv
// Pipeline/unit-facing signal bundle of the multi-cycle scheduler.
interface ex_mc_sched_if;
  logic        issue_vld;
  logic [4:0]  issue_func;
  logic        flush;
  logic [31:0] unit_res;
  logic        unit_start;
  logic [1:0]  unit_sel;
  logic        stall;
  logic        res_vld;
  logic [31:0] res;

  modport master (
    output issue_vld, issue_func, flush, unit_res,
    input  unit_start, unit_sel, stall, res_vld, res
  );

  modport slave (
    input  issue_vld, issue_func, flush, unit_res,
    output unit_start, unit_sel, stall, res_vld, res
  );
endinterface

// File: rtl/ex_mc_sched_lat_counter.sv
// Loadable down-counter that saturates at zero; times the multi-cycle latency.
module ex_lat_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ex_mc_sched.sv
// Issues divide/FPU ops to the shared iterative unit, stalls the pipeline for
// the unit latency and presents the captured result for one cycle.
module ex_mc_sched
  import ex_sched_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned FPU_LAT = FPU_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  ex_mc_sched_if.slave  bus
);

  localparam int unsigned MAX_LAT = (DIV_LAT > FPU_LAT) ? DIV_LAT : FPU_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);
  localparam logic [CW-1:0] FPU_LOAD = CW'(FPU_LAT - 2);

  sched_state_e state_q, state_d;
  op_class_e    sel_q, sel_d;
  logic [31:0]  res_q, res_d;

  op_class_e    issue_cls;
  op_class_e    sel_o;
  logic         start_o;
  logic         stall_o;
  logic         res_vld_o;
  logic         cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic         cnt_dec;
  logic         cnt_zero;

  ex_lat_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    issue_cls    = op_class(bus.issue_func);
    state_d      = state_q;
    sel_d        = sel_q;
    res_d        = res_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    start_o      = 1'b0;
    stall_o      = 1'b0;
    sel_o        = CL_NONE;
    res_vld_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.issue_vld && (issue_cls != CL_NONE) && !bus.flush) begin
          start_o      = 1'b1;
          stall_o      = 1'b1;
          sel_o        = issue_cls;
          sel_d        = issue_cls;
          cnt_load     = 1'b1;
          cnt_load_val = (issue_cls == CL_DIV) ? DIV_LOAD : FPU_LOAD;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_o = !bus.flush;
        sel_o   = sel_q;
        if (bus.flush) begin
          sel_d   = CL_NONE;
          state_d = S_IDLE;
        end else if (cnt_zero) begin
          res_d   = bus.unit_res;
          state_d = S_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE: begin
        res_vld_o = !bus.flush;
        sel_d     = CL_NONE;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = CL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sel_q   <= CL_NONE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
    end
  end

  // Issue-cycle outputs depend on live inputs, so gate them while reset is held.
  assign bus.unit_start = rst & start_o;
  assign bus.stall      = rst & stall_o;
  assign bus.res_vld    = rst & res_vld_o;
  assign bus.unit_sel   = rst ? sel_o : CL_NONE;
  assign bus.res        = res_q;

endmodule

// File: tb/tb_ex_mc_sched.sv
// Directed bench for ex_mc_sched: a cycle-count model of the issue/hold/result
// timeline checked every cycle, plus literal expectations on key events.
module tb_ex_mc_sched;
  import ex_sched_pkg::*;

  localparam int DLAT = 33;
  localparam int FLAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic hold7 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_mc_sched_if bus ();

  ex_mc_sched #(.DIV_LAT(DLAT), .FPU_LAT(FLAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [4:0] f);
    if (f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) return 1;
    if (f inside {ALU_FCVTSW, ALU_FCVTSWU, ALU_FCVTWS, ALU_FCVTWUS, ALU_FMULS}) return 2;
    return 0;
  endfunction

  // Model: an accepted op at cycle t0 holds t0..t0+lat-1, result at t0+lat.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_t0, m_lat, m_cls, k, c;
  logic [31:0] m_cap;
  logic        e_start, e_stall, e_vld;
  logic [1:0]  e_sel;

  always @(negedge clk) begin
    e_start = 1'b0; e_stall = 1'b0; e_vld = 1'b0; e_sel = 2'd0;
    if (!rst) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      c = cls_of(bus.issue_func);
      if (bus.issue_vld && c != 0 && !bus.flush) begin
        e_start = 1'b1; e_stall = 1'b1; e_sel = 2'(c);
        m_busy = 1'b1; m_t0 = cyc; m_cls = c;
        m_lat = (c == 1) ? DLAT : FLAT;
      end
    end else begin
      k = cyc - m_t0;
      if (k < m_lat) begin
        e_stall = !bus.flush;
        e_sel   = 2'(m_cls);
        if (bus.flush) m_busy = 1'b0;
        else if (k == m_lat - 1) m_cap = bus.unit_res;
      end else begin
        e_vld  = !bus.flush;
        m_busy = 1'b0;
      end
    end
    chk("m_start", 32'(bus.unit_start), 32'(e_start));
    chk("m_stall", 32'(bus.stall), 32'(e_stall));
    chk("m_sel", 32'(bus.unit_sel), 32'(e_sel));
    chk("m_res_vld", 32'(bus.res_vld), 32'(e_vld));
    if (e_vld) chk("m_res", bus.res, m_cap);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.unit_res = hold7 ? 32'h0000_0007 : $urandom;
  endtask

  task automatic wait_res(input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.res_vld === 1'b1) break;
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL wait_res timeout actual=%0d required<=%0d", n, budget);
        break;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic [4:0] none_ops [3];
  int n1, n2;

  initial begin
    none_ops[0] = ALU_ADD; none_ops[1] = ALU_MUL; none_ops[2] = ALU_SLT;
    rst = 1'b0;
    bus.issue_vld = 1'b0; bus.issue_func = ALU_ADD; bus.flush = 1'b0; bus.unit_res = '0;
    #2;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_start", 32'(bus.unit_start), 32'd0);
    chk("rst_res_vld", 32'(bus.res_vld), 32'd0);
    chk("rst_res", bus.res, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Single-cycle classes never stall.
    foreach (none_ops[i]) begin
      bus.issue_vld = 1'b1; bus.issue_func = none_ops[i];
      @(negedge clk);
      chk("none_stall", 32'(bus.stall), 32'd0);
      repeat (2) tick();
    end
    bus.issue_vld = 1'b0;
    tick();

    // DIV with a fixed unit result.
    hold7 = 1'b1;
    tick();
    bus.issue_vld = 1'b1; bus.issue_func = ALU_DIV;
    wait_res(40, n1);
    chk("div_lat", 32'(n1), 32'd33);
    chk("div_res", bus.res, 32'h0000_0007);
    tick();
    bus.issue_vld = 1'b0; hold7 = 1'b0;
    tick();

    // Back-to-back FPU ops.
    bus.issue_vld = 1'b1; bus.issue_func = ALU_FMULS;
    wait_res(10, n1);
    chk("fpu1_lat", 32'(n1), 32'd4);
    chk("fpu1_done_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.issue_func = ALU_FCVTWS;
    wait_res(10, n2);
    chk("fpu2_total", 32'(n1 + 1 + n2), 32'd9);
    tick();
    bus.issue_vld = 1'b0;
    tick();

    // REM flushed at busy cycle 10, then DIV issues the next cycle.
    bus.issue_vld = 1'b1; bus.issue_func = ALU_REM;
    repeat (10) tick();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.flush = 1'b0; bus.issue_func = ALU_DIV;
    wait_res(40, n1);
    chk("post_flush_div_lat", 32'(n1), 32'd33);
    tick();
    bus.issue_vld = 1'b0;

    // Multi-cycle code without issue_vld.
    bus.issue_func = ALU_DIVU;
    @(negedge clk);
    chk("novld_start", 32'(bus.unit_start), 32'd0);
    repeat (2) tick();

    // Flush landing in the result cycle.
    bus.issue_vld = 1'b1; bus.issue_func = ALU_FCVTSW;
    repeat (4) tick();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("done_flush_res_vld", 32'(bus.res_vld), 32'd0);
    tick();
    bus.flush = 1'b0; bus.issue_vld = 1'b0;
    tick();

    // Asynchronous reset with the counter at 5.
    bus.issue_vld = 1'b1; bus.issue_func = ALU_DIV;
    repeat (27) tick();
    bus.issue_vld = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    chk("mid_rst_start", 32'(bus.unit_start), 32'd0);
    chk("mid_rst_res_vld", 32'(bus.res_vld), 32'd0);
    chk("mid_rst_sel", 32'(bus.unit_sel), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    bus.issue_vld = 1'b1; bus.issue_func = ALU_FMULS;
    @(negedge clk);
    chk("post_rst_start", 32'(bus.unit_start), 32'd1);
    repeat (6) tick();
    bus.issue_vld = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
